uart_rx_os: RTL and testbench



---
 rtl/uart_pkg.sv | 21 ++
 rtl/sync_2ff.sv | 23 ++
 rtl/uart_rx_os.sv | 132 +++++++++++++
 tb/tb_uart_rx_os.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: parity modes, receive states and counter sizing.
package uart_pkg;

    localparam int unsigned PAR_NONE = 0;
    localparam int unsigned PAR_ODD  = 1;
    localparam int unsigned PAR_EVEN = 2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } rx_state_e;

    // Bits needed to hold 0..n-1, never less than one.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop bit synchroniser with a parametrised reset value.
module sync_2ff #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic i_d,
    output logic o_q
);

    logic r_meta;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_meta <= RST_VAL;
            o_q    <= RST_VAL;
        end else begin
            r_meta <= i_d;
            o_q    <= r_meta;
        end
    end

endmodule

// File: rtl/uart_rx_os.sv
// Oversampling UART receiver: mid-bit sampling, optional parity, 1 or 2 stop bits,
// start-glitch rejection, and one-cycle done strobe with parity/framing flags.
module uart_rx_os
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 16,
    parameter int unsigned DATA_BITS    = 8,
    parameter int unsigned PARITY       = 0,
    parameter int unsigned STOP_BITS    = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 i_rx_data,
    output logic                 o_rx_done,
    output logic [DATA_BITS-1:0] o_rx_data,
    output logic                 o_parity_err,
    output logic                 o_frame_err
);

    localparam int unsigned CW = cnt_width(CLKS_PER_BIT);
    localparam int unsigned IW = cnt_width(DATA_BITS);

    localparam logic [CW-1:0] C_HALF_M1   = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] C_FULL_M1   = CW'(CLKS_PER_BIT - 1);
    localparam logic [IW-1:0] C_LAST_BIT  = IW'(DATA_BITS - 1);
    localparam logic          C_LAST_STOP = 1'(STOP_BITS - 1);
    localparam logic          C_HAS_PAR   = (PARITY != PAR_NONE);
    localparam logic          C_ODD       = (PARITY == PAR_ODD);

    logic                 w_rx_s;
    rx_state_e            r_state;
    logic [CW-1:0]        r_cnt;
    logic [IW-1:0]        r_bit_idx;
    logic                 r_stop_idx;
    logic [DATA_BITS-1:0] r_shift;
    logic                 r_par;
    logic                 r_perr;
    logic                 r_ferr;

    sync_2ff #(
        .RST_VAL (1'b1)
    ) u_sync (
        .clk   (clk),
        .reset (reset),
        .i_d   (i_rx_data),
        .o_q   (w_rx_s)
    );

    // Frame FSM and datapath; outputs update only on the final stop sample.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_cnt        <= '0;
            r_bit_idx    <= '0;
            r_stop_idx   <= 1'b0;
            r_shift      <= '0;
            r_par        <= 1'b0;
            r_perr       <= 1'b0;
            r_ferr       <= 1'b0;
            o_rx_done    <= 1'b0;
            o_rx_data    <= '0;
            o_parity_err <= 1'b0;
            o_frame_err  <= 1'b0;
        end else begin
            o_rx_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (!w_rx_s) begin
                        r_state <= ST_START;
                        r_cnt   <= '0;
                        r_par   <= 1'b0;
                        r_perr  <= 1'b0;
                        r_ferr  <= 1'b0;
                    end
                end
                ST_START: begin
                    if (r_cnt == C_HALF_M1) begin
                        r_cnt     <= '0;
                        r_bit_idx <= '0;
                        r_state   <= w_rx_s ? ST_IDLE : ST_DATA;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                ST_DATA: begin
                    if (r_cnt == C_FULL_M1) begin
                        r_cnt   <= '0;
                        r_shift <= {w_rx_s, r_shift[DATA_BITS-1:1]};
                        r_par   <= r_par ^ w_rx_s;
                        if (r_bit_idx == C_LAST_BIT) begin
                            r_stop_idx <= 1'b0;
                            r_state    <= C_HAS_PAR ? ST_PARITY : ST_STOP;
                        end else begin
                            r_bit_idx <= r_bit_idx + 1'b1;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                ST_PARITY: begin
                    if (r_cnt == C_FULL_M1) begin
                        r_cnt   <= '0;
                        r_perr  <= r_par ^ w_rx_s ^ C_ODD;
                        r_state <= ST_STOP;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                ST_STOP: begin
                    if (r_cnt == C_FULL_M1) begin
                        r_cnt <= '0;
                        // Leave at mid-stop so an immediate next start is not missed.
                        if (r_stop_idx == C_LAST_STOP) begin
                            o_rx_data    <= r_shift;
                            o_parity_err <= r_perr & C_HAS_PAR;
                            o_frame_err  <= r_ferr | ~w_rx_s;
                            o_rx_done    <= 1'b1;
                            r_state      <= ST_IDLE;
                        end else begin
                            r_ferr     <= r_ferr | ~w_rx_s;
                            r_stop_idx <= 1'b1;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx_os.sv
// Directed bench for uart_rx_os: 8N1, 8E1 and 8N2 instances driven from a vector table.
module tb_uart_rx_os;

    localparam int N = 16;

    logic       clk = 1'b0;
    logic       reset;
    logic       rx_line [3];
    logic       done    [3];
    logic [7:0] data    [3];
    logic       perr    [3];
    logic       ferr    [3];

    int         cyc = 0;
    int         dcnt [3] = '{0, 0, 0};
    int         dcyc [3] = '{0, 0, 0};
    logic [7:0] hist [64];
    int         passed = 0;
    int         total  = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    uart_rx_os u_8n1 (
        .clk (clk), .reset (reset), .i_rx_data (rx_line[0]),
        .o_rx_done (done[0]), .o_rx_data (data[0]),
        .o_parity_err (perr[0]), .o_frame_err (ferr[0])
    );

    uart_rx_os #(.PARITY(2)) u_8e1 (
        .clk (clk), .reset (reset), .i_rx_data (rx_line[1]),
        .o_rx_done (done[1]), .o_rx_data (data[1]),
        .o_parity_err (perr[1]), .o_frame_err (ferr[1])
    );

    uart_rx_os #(.STOP_BITS(2)) u_8n2 (
        .clk (clk), .reset (reset), .i_rx_data (rx_line[2]),
        .o_rx_done (done[2]), .o_rx_data (data[2]),
        .o_parity_err (perr[2]), .o_frame_err (ferr[2])
    );

    // Strobe recorder: counts, cycle of last strobe, and 8N1 data history.
    always @(negedge clk) begin
        for (int k = 0; k < 3; k++) begin
            if (done[k] === 1'b1) begin
                if (k == 0 && dcnt[0] < 64) hist[dcnt[0]] = data[0];
                dcnt[k] = dcnt[k] + 1;
                dcyc[k] = cyc;
            end
        end
    end

    typedef struct {
        logic [1:0] inst;
        logic [7:0] d;
        logic       pbit;
        logic       s2;
        logic [7:0] xd;
        logic       xp;
        logic       xf;
    } vec_t;

    vec_t vt [7];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total = total + 1;
        if (act === exp) passed = passed + 1;
        else $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    endtask

    task automatic wait_bits(input int n);
        repeat (n * N) @(negedge clk);
    endtask

    task automatic send_frame(input logic [1:0] inst, input logic [7:0] d,
                              input logic pbit, input logic s2);
        rx_line[inst] = 1'b0;
        wait_bits(1);
        for (int i = 0; i < 8; i++) begin
            rx_line[inst] = d[i];
            wait_bits(1);
        end
        if (inst == 2'd1) begin
            rx_line[inst] = pbit;
            wait_bits(1);
        end
        rx_line[inst] = 1'b1;
        wait_bits(1);
        if (inst == 2'd2) begin
            rx_line[inst] = s2;
            wait_bits(1);
        end
        rx_line[inst] = 1'b1;
    endtask

    function automatic int exp_latency(input logic [1:0] inst);
        int f;
        f = 8 + ((inst == 2'd1) ? 1 : 0) + ((inst == 2'd2) ? 2 : 1);
        return 3 + N / 2 + f * N;
    endfunction

    initial begin
        int c0;
        int n0;
        logic [1:0] ix;

        vt[0] = '{2'd0, 8'h71, 1'b0, 1'b1, 8'h71, 1'b0, 1'b0};
        vt[1] = '{2'd1, 8'h71, 1'b0, 1'b1, 8'h71, 1'b0, 1'b0};
        vt[2] = '{2'd1, 8'h71, 1'b1, 1'b1, 8'h71, 1'b1, 1'b0};
        vt[3] = '{2'd1, 8'hA5, 1'b0, 1'b1, 8'hA5, 1'b0, 1'b0};
        vt[4] = '{2'd1, 8'h01, 1'b0, 1'b1, 8'h01, 1'b1, 1'b0};
        vt[5] = '{2'd2, 8'hA5, 1'b0, 1'b0, 8'hA5, 1'b0, 1'b1};
        vt[6] = '{2'd2, 8'h3C, 1'b0, 1'b1, 8'h3C, 1'b0, 1'b0};

        reset = 1'b1;
        for (int k = 0; k < 3; k++) rx_line[k] = 1'b1;
        repeat (4) @(negedge clk);
        check("reset_done",  32'(done[0]), 32'd0);
        check("reset_data",  32'(data[0]), 32'd0);
        check("reset_perr",  32'(perr[0]), 32'd0);
        check("reset_ferr",  32'(ferr[0]), 32'd0);
        check("reset_data1", 32'(data[1]), 32'd0);
        check("reset_data2", 32'(data[2]), 32'd0);
        reset = 1'b0;
        repeat (4) @(negedge clk);

        for (int i = 0; i < 7; i++) begin
            ix = vt[i].inst;
            c0 = cyc;
            n0 = dcnt[ix];
            send_frame(ix, vt[i].d, vt[i].pbit, vt[i].s2);
            repeat (24) @(negedge clk);
            check($sformatf("v%0d_strobes", i), 32'(dcnt[ix] - n0), 32'd1);
            check($sformatf("v%0d_latency", i), 32'(dcyc[ix] - c0), 32'(exp_latency(ix)));
            check($sformatf("v%0d_data", i), 32'(data[ix]), 32'(vt[i].xd));
            check($sformatf("v%0d_perr", i), 32'(perr[ix]), 32'(vt[i].xp));
            check($sformatf("v%0d_ferr", i), 32'(ferr[ix]), 32'(vt[i].xf));
        end

        // Three-cycle low pulse must be rejected as a glitch.
        n0 = dcnt[0];
        rx_line[0] = 1'b0;
        repeat (3) @(negedge clk);
        rx_line[0] = 1'b1;
        repeat (40) @(negedge clk);
        check("glitch_strobes", 32'(dcnt[0] - n0), 32'd0);
        check("glitch_data",    32'(data[0]), 32'h71);
        check("glitch_perr",    32'(perr[0]), 32'd0);
        check("glitch_ferr",    32'(ferr[0]), 32'd0);

        // Back-to-back frames with zero idle gap.
        n0 = dcnt[0];
        send_frame(2'd0, 8'h00, 1'b0, 1'b1);
        send_frame(2'd0, 8'hFF, 1'b0, 1'b1);
        send_frame(2'd0, 8'h55, 1'b0, 1'b1);
        repeat (24) @(negedge clk);
        check("b2b_strobes", 32'(dcnt[0] - n0), 32'd3);
        check("b2b_data0",   32'(hist[n0]),     32'h00);
        check("b2b_data1",   32'(hist[n0 + 1]), 32'hFF);
        check("b2b_data2",   32'(hist[n0 + 2]), 32'h55);
        check("b2b_ferr",    32'(ferr[0]),      32'd0);

        // Reset asserted in data bit 4 of 0x3C and held until the line is idle.
        n0 = dcnt[0];
        rx_line[0] = 1'b0;
        wait_bits(1);
        for (int i = 0; i < 4; i++) begin
            rx_line[0] = (8'h3C >> i) & 8'h01 ? 1'b1 : 1'b0;
            wait_bits(1);
        end
        rx_line[0] = 1'b1;
        repeat (8) @(negedge clk);
        reset = 1'b1;
        repeat (8) @(negedge clk);
        check("rst_mid_data", 32'(data[0]), 32'd0);
        check("rst_mid_perr", 32'(perr[0]), 32'd0);
        check("rst_mid_ferr", 32'(ferr[0]), 32'd0);
        for (int i = 5; i < 8; i++) begin
            rx_line[0] = (8'h3C >> i) & 8'h01 ? 1'b1 : 1'b0;
            wait_bits(1);
        end
        rx_line[0] = 1'b1;
        wait_bits(1);
        reset = 1'b0;
        repeat (40) @(negedge clk);
        check("rst_mid_strobes", 32'(dcnt[0] - n0), 32'd0);
        check("rst_mid_hold",    32'(data[0]),      32'd0);

        c0 = cyc;
        n0 = dcnt[0];
        send_frame(2'd0, 8'hC3, 1'b0, 1'b1);
        repeat (24) @(negedge clk);
        check("post_rst_strobes", 32'(dcnt[0] - n0), 32'd1);
        check("post_rst_latency", 32'(dcyc[0] - c0), 32'(exp_latency(2'd0)));
        check("post_rst_data",    32'(data[0]),      32'hC3);
        check("post_rst_perr",    32'(perr[0]),      32'd0);
        check("post_rst_ferr",    32'(ferr[0]),      32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
